// File: rtl/ddr_deser_pkg.sv
// Shared definitions for the DDR deserializer: framing FSM encoding,
// sync-slot interval and output FIFO depth.
package ddr_deser_pkg;

   typedef enum logic [0:0] {
      StHunt = 1'b0,
      StLock = 1'b1
   } deser_state_e;

   // Every SLOT_INTERVAL-th completed word in LOCK is a sync slot.
   localparam int unsigned SLOT_INTERVAL = 8;
   localparam int unsigned SLOT_CW       = $clog2(SLOT_INTERVAL);

   // Output FIFO capacity, including the registered output stage.
   localparam int unsigned FIFO_DEPTH = 2;

   // Loss counter width covers LOSS_MAX up to 15.
   localparam int unsigned LOSS_CW = 4;

   // True when the slot counter sits on the last word before a sync slot wraps.
   function automatic logic slot_is_last(input logic [SLOT_CW-1:0] cnt);
      return cnt == SLOT_CW'(SLOT_INTERVAL - 1);
   endfunction

endpackage

// File: rtl/ddr_deser_fifo2.sv
// Two-entry word FIFO whose head entry is the registered WORD/VALID output.
// A full FIFO accepts a push only when it pops in the same cycle; otherwise the
// incoming word is dropped and the sticky overflow flag is raised.
module ddr_deser_fifo2
   import ddr_deser_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic [WIDTH-1:0] word,
   output logic             valid,
   output logic             overflow
);

   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic             head_vld_q;
   logic             tail_vld_q;
   logic             ovf_q;
   logic             pop;
   logic [1:0]       occ;
   logic             full;

   // Pop and fullness decode from the current occupancy.
   always_comb begin
      pop  = head_vld_q && ready;
      occ  = {1'b0, head_vld_q} + {1'b0, tail_vld_q};
      full = (occ == 2'(FIFO_DEPTH));
   end

   // Head/tail storage; the tail is only ever occupied while the head is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         head_vld_q <= 1'b0;
         tail_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (push && full && !pop) begin
            ovf_q <= 1'b1;
         end
         if (pop) begin
            if (tail_vld_q) begin
               head_q     <= tail_q;
               head_vld_q <= 1'b1;
               tail_vld_q <= push;
               if (push) begin
                  tail_q <= push_data;
               end
            end else if (push) begin
               head_q     <= push_data;
               head_vld_q <= 1'b1;
            end else begin
               head_vld_q <= 1'b0;
            end
         end else if (push) begin
            if (!head_vld_q) begin
               head_q     <= push_data;
               head_vld_q <= 1'b1;
            end else if (!tail_vld_q) begin
               tail_q     <= push_data;
               tail_vld_q <= 1'b1;
            end
         end
      end
   end

   assign word     = head_q;
   assign valid    = head_vld_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/ddr_deserializer.sv
// DDR input deserializer: assembles bit pairs from the pad into WIDTH-bit
// words, hunts for a sync word at either pair phase, then frames words at
// the locked phase and supervises periodic sync slots to detect loss of lock.
module ddr_deserializer
   import ddr_deser_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5,
   parameter int unsigned      LOSS_MAX  = 4
) (
   input  logic             C,
   input  logic             R,
   input  logic             CLOCK_ENABLE,
   input  logic             D_IN_0,
   input  logic             D_IN_1,
   input  logic             ALIGN,
   output logic [WIDTH-1:0] WORD,
   output logic             VALID,
   input  logic             READY,
   output logic             LOCKED,
   output logic             PHASE,
   output logic             OVERFLOW
);

   localparam int unsigned         HALF       = WIDTH / 2;
   localparam int unsigned         PCW        = $clog2(HALF);
   localparam logic [PCW-1:0]      PAIR_LAST  = PCW'(HALF - 1);
   localparam logic [LOSS_CW-1:0]  LOSS_LIMIT = LOSS_CW'(LOSS_MAX);

   deser_state_e        state_q;
   logic [WIDTH:0]      sr_q;
   logic [WIDTH:0]      sr_nxt;
   logic [PCW-1:0]      pair_q;
   logic [SLOT_CW-1:0]  slot_q;
   logic [LOSS_CW-1:0]  loss_q;
   logic                locked_q;
   logic                phase_q;
   logic                match0;
   logic                match1;
   logic [WIDTH-1:0]    win_sel;
   logic                word_done;

   // The two oldest register bits fall off on every shift and are never read.
   logic unused_sr_top;
   assign unused_sr_top = ^sr_q[WIDTH:WIDTH-1];

   // Windows are taken from the shifted value so a word completes in the
   // same cycle its last pair arrives.
   always_comb begin
      sr_nxt    = {sr_q[WIDTH-2:0], D_IN_0, D_IN_1};
      match0    = (sr_nxt[WIDTH-1:0] == SYNC_WORD);
      match1    = (sr_nxt[WIDTH:1] == SYNC_WORD);
      win_sel   = phase_q ? sr_nxt[WIDTH:1] : sr_nxt[WIDTH-1:0];
      word_done = CLOCK_ENABLE && !ALIGN && (state_q == StLock) && (pair_q == PAIR_LAST);
   end

   // Pair shifter, D_IN_0 is the older bit of each pair.
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         sr_q <= '0;
      end else if (CLOCK_ENABLE) begin
         sr_q <= sr_nxt;
      end
   end

   // Framing FSM with pair/slot/loss counters and registered LOCKED/PHASE.
   // ALIGN acts even while the clock enable is low so a re-hunt request is
   // never lost; the partial word is discarded by clearing the pair counter.
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state_q  <= StHunt;
         pair_q   <= '0;
         slot_q   <= '0;
         loss_q   <= '0;
         locked_q <= 1'b0;
         phase_q  <= 1'b0;
      end else if (ALIGN) begin
         state_q  <= StHunt;
         pair_q   <= '0;
         slot_q   <= '0;
         loss_q   <= '0;
         locked_q <= 1'b0;
      end else if (CLOCK_ENABLE) begin
         unique case (state_q)
            StHunt: begin
               if (match0 || match1) begin
                  state_q  <= StLock;
                  locked_q <= 1'b1;
                  phase_q  <= !match0;
                  pair_q   <= '0;
                  slot_q   <= '0;
                  loss_q   <= '0;
               end
            end
            StLock: begin
               if (pair_q == PAIR_LAST) begin
                  pair_q <= '0;
                  if (slot_is_last(slot_q)) begin
                     slot_q <= '0;
                     if (win_sel == SYNC_WORD) begin
                        loss_q <= '0;
                     end else if (loss_q + LOSS_CW'(1) >= LOSS_LIMIT) begin
                        loss_q   <= LOSS_LIMIT;
                        state_q  <= StHunt;
                        locked_q <= 1'b0;
                     end else begin
                        loss_q <= loss_q + LOSS_CW'(1);
                     end
                  end else begin
                     slot_q <= slot_q + SLOT_CW'(1);
                  end
               end else begin
                  pair_q <= pair_q + PCW'(1);
               end
            end
            default: begin
               state_q  <= StHunt;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   ddr_deser_fifo2 #(
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk       (C),
      .rst       (R),
      .push      (word_done),
      .push_data (win_sel),
      .ready     (READY),
      .word      (WORD),
      .valid     (VALID),
      .overflow  (OVERFLOW)
   );

   assign LOCKED = locked_q;
   assign PHASE  = phase_q;

endmodule

// File: tb/tb_ddr_deserializer.sv
// Randomized and directed bench for ddr_deserializer, checked against a
// bit-history reference model.
module tb_ddr_deserializer;

   localparam int unsigned      W    = 8;
   localparam int unsigned      HALF = W / 2;
   localparam logic [W-1:0]     SYNC = 8'hA5;
   localparam int unsigned      LMAX = 4;

   logic         c = 1'b0;
   logic         r;
   logic         ce;
   logic         d0;
   logic         d1;
   logic         align;
   logic         ready;
   logic [W-1:0] word;
   logic         valid;
   logic         locked;
   logic         phase;
   logic         overflow;

   ddr_deserializer #(
      .WIDTH     (W),
      .SYNC_WORD (SYNC),
      .LOSS_MAX  (LMAX)
   ) dut (
      .C            (c),
      .R            (r),
      .CLOCK_ENABLE (ce),
      .D_IN_0       (d0),
      .D_IN_1       (d1),
      .ALIGN        (align),
      .WORD         (word),
      .VALID        (valid),
      .READY        (ready),
      .LOCKED       (locked),
      .PHASE        (phase),
      .OVERFLOW     (overflow)
   );

   always #5 c = ~c;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: full received bit history plus framing bookkeeping.
   bit           hist[$];
   bit           m_lock;
   bit           m_phase;
   bit           m_ovf;
   int           m_pairs;
   int           m_words;
   int           m_loss;
   logic [W-1:0] mq[$];
   logic [W-1:0] seen[$];
   bit           tx[$];

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < W + 1; i++) hist.push_back(1'b0);
      m_lock  = 0;
      m_phase = 0;
      m_ovf   = 0;
      m_pairs = 0;
      m_words = 0;
      m_loss  = 0;
      mq.delete();
   endtask

   // Word formed from the newest bits, skipping p newest bits; MSB = oldest.
   function automatic logic [W-1:0] win(input int p);
      logic [W-1:0] w;
      int n;
      n = hist.size();
      for (int i = 0; i < W; i++) w[i] = hist[n - 1 - p - i];
      return w;
   endfunction

   task automatic model_step(input bit e, input bit b0, input bit b1, input bit a, input bit rd);
      bit           pop;
      bit           push;
      logic [W-1:0] w;
      pop  = (mq.size() > 0) && rd;
      push = 0;
      w    = '0;
      if (e) begin
         hist.push_back(b0);
         hist.push_back(b1);
      end
      if (a) begin
         m_lock = 0;
      end else if (e) begin
         if (!m_lock) begin
            if (win(0) == SYNC || win(1) == SYNC) begin
               m_lock  = 1;
               m_phase = (win(0) != SYNC);
               m_pairs = 0;
               m_words = 0;
               m_loss  = 0;
            end
         end else begin
            m_pairs++;
            if (m_pairs % HALF == 0) begin
               w = win(m_phase ? 1 : 0);
               push = 1;
               m_words++;
               if (m_words % 8 == 0) begin
                  if (w == SYNC) m_loss = 0;
                  else m_loss++;
                  if (m_loss >= LMAX) m_lock = 0;
               end
            end
         end
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < 2) mq.push_back(w);
         else m_ovf = 1;
      end
   endtask

   task automatic compare();
      check_eq("valid", valid, (mq.size() > 0));
      check_eq("locked", locked, m_lock);
      check_eq("phase", phase, m_phase);
      check_eq("overflow", overflow, m_ovf);
      if (mq.size() > 0) check_eq("word", word, mq[0]);
   endtask

   task automatic step(input bit e, input bit b0, input bit b1, input bit a, input bit rd);
      ce    = e;
      d0    = b0;
      d1    = b1;
      align = a;
      ready = rd;
      if (valid && ready) seen.push_back(word);
      @(posedge c);
      model_step(e, b0, b1, a, rd);
      #1;
      compare();
   endtask

   task automatic do_reset();
      r = 1'b1;
      model_reset();
      seen.delete();
      tx.delete();
      @(posedge c);
      #1;
      compare();
      check_eq("reset_word", word, 0);
      r = 1'b0;
   endtask

   task automatic push_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) tx.push_back(w[i]);
   endtask

   task automatic drain(input int ready_pct, input int ce_pct, input int align_pct);
      bit e;
      bit a;
      bit rd;
      bit b0;
      bit b1;
      while (tx.size() >= 2) begin
         e  = ($urandom_range(99) < ce_pct);
         a  = ($urandom_range(99) < align_pct);
         rd = ($urandom_range(99) < ready_pct);
         if (e) begin
            b0 = tx.pop_front();
            b1 = tx.pop_front();
         end else begin
            b0 = 1'($urandom);
            b1 = 1'($urandom);
         end
         step(e, b0, b1, a, rd);
      end
   endtask

   // Pop-only cycles: no new bits are shifted in.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
   endtask

   task automatic check_seen(input string tag, input int n, input logic [W-1:0] e0,
                             input logic [W-1:0] e1);
      logic [31:0] g;
      check_eq({tag, "_count"}, seen.size(), n);
      for (int i = 0; i < n; i++) begin
         g = (i < seen.size()) ? {24'h0, seen[i]} : 32'hFFFF_FFFF;
         check_eq({tag, "_word"}, g, (i == 0) ? {24'h0, e0} : {24'h0, e1});
      end
   endtask

   initial begin
      r = 1'b1; ce = 1'b0; d0 = 1'b0; d1 = 1'b0; align = 1'b0; ready = 1'b0;
      do_reset();

      // Phase-0 stream.
      push_word(SYNC); push_word(8'h3C); push_word(8'hC3);
      drain(100, 100, 0);
      check_eq("s033_locked", locked, 1);
      check_eq("s033_phase", phase, 0);
      idle(3);
      check_seen("s033", 2, 8'h3C, 8'hC3);

      // Same stream delayed by one bit.
      do_reset();
      tx.push_back(1'b0);
      push_word(SYNC); push_word(8'h3C); push_word(8'hC3);
      tx.push_back(1'b0);
      drain(100, 100, 0);
      check_eq("s034_locked", locked, 1);
      check_eq("s034_phase", phase, 1);
      idle(3);
      check_seen("s034", 2, 8'h3C, 8'hC3);

      // Back-pressure overflow.
      do_reset();
      push_word(SYNC);
      drain(100, 100, 0);
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      drain(0, 100, 0);
      check_eq("s035_overflow", overflow, 1);
      idle(4);
      check_seen("s035", 2, 8'h11, 8'h22);

      // Loss of lock after LMAX bad sync slots, then relock.
      do_reset();
      push_word(SYNC);
      for (int s = 0; s < LMAX; s++) begin
         for (int k = 0; k < 7; k++) push_word(8'($urandom));
         push_word(8'h00);
      end
      drain(100, 100, 0);
      check_eq("s036_unlocked", locked, 0);
      push_word(SYNC); push_word(8'h5A);
      drain(100, 100, 0);
      check_eq("s036_relocked", locked, 1);

      // ALIGN with one held word and a partial word in flight.
      do_reset();
      push_word(SYNC); push_word(8'h5A);
      drain(0, 100, 0);
      tx.push_back(1'b0); tx.push_back(1'b0); tx.push_back(1'b1); tx.push_back(1'b1);
      drain(0, 50, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("s037_unlocked", locked, 0);
      for (int i = 0; i < 12; i++) step(1'(i % 2), 1'b0, 1'b0, 1'b0, 1'b1);
      check_seen("s037", 1, 8'h5A, 8'h00);

      // Asynchronous reset mid-stream while VALID is high.
      do_reset();
      tx.push_back(1'b0);
      push_word(SYNC); push_word(8'h11); push_word(8'h22); push_word(8'h33);
      tx.push_back(1'b0);
      drain(0, 100, 0);
      check_eq("s032_pre_valid", valid, 1);
      check_eq("s032_pre_overflow", overflow, 1);
      #3;
      r = 1'b1;
      #1;
      check_eq("s032_valid", valid, 0);
      check_eq("s032_locked", locked, 0);
      check_eq("s032_overflow", overflow, 0);
      check_eq("s032_phase", phase, 0);
      check_eq("s032_word", word, 0);
      model_reset();
      seen.delete();
      @(posedge c);
      #1;
      compare();
      r = 1'b0;

      // Randomized framed traffic with slips, corrupted slots and ALIGN.
      do_reset();
      for (int f = 0; f < 120; f++) begin
         if (f % 20 == 10) tx.push_back(1'($urandom));
         if ($urandom_range(3) == 0) push_word(8'($urandom));
         else push_word(SYNC);
         for (int k = 0; k < 7; k++) push_word(8'($urandom));
         drain(90, 80, 1);
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
